// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 key matrix scanner with debounce, one KeyValid pulse per press
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       En,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Key,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  if (SETTLE_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {S_SCAN, S_PRESS_DB, S_HELD} state_e;

  state_e        state_q;
  logic [3:0]    sync1_q, rs_q;
  logic [1:0]    ci_q;
  logic [3:0]    col_q, key_q, pat_q;
  logic          key_valid_q, key_held_q;
  logic [SW-1:0] dwell_q;
  logic [DW-1:0] db_q, rel_q;
  logic [1:0]    ci_d;
  logic [1:0]    row_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q;
`endif

  function automatic logic [3:0] col_of(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  assign ci_d = ci_q + 2'd1;

  // Lowest-numbered low row wins when several rows on one column are closed.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat_q[i]) row_idx = 2'(i);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= Row;
      rs_q    <= sync1_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_SCAN;
      ci_q        <= 2'd0;
      col_q       <= 4'hF;
      key_q       <= 4'h0;
      pat_q       <= 4'hF;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      dwell_q     <= '0;
      db_q        <= '0;
      rel_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (!En) begin
        state_q    <= S_SCAN;
        ci_q       <= 2'd0;
        col_q      <= 4'hF;
        key_held_q <= 1'b0;
        dwell_q    <= '0;
        db_q       <= '0;
        rel_q      <= '0;
`ifdef KEYPAD_REPEAT_EN
        rep_q      <= '0;
`endif
      end else if (col_q == 4'hF) begin
        // Strobe the first column before dwell counting so it gets a full settle window.
        col_q <= col_of(ci_q);
      end else begin
        case (state_q)
          S_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
              dwell_q <= '0;
              if (rs_q == 4'hF) begin
                ci_q  <= ci_d;
                col_q <= col_of(ci_d);
              end else begin
                pat_q   <= rs_q;
                db_q    <= '0;
                state_q <= S_PRESS_DB;
              end
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          S_PRESS_DB: begin
            if (rs_q != pat_q) begin
              db_q    <= '0;
              ci_q    <= ci_d;
              col_q   <= col_of(ci_d);
              state_q <= S_SCAN;
            end else if (db_q == DB_LAST) begin
              db_q        <= '0;
              rel_q       <= '0;
              key_q       <= {row_idx, ci_q};
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_q       <= '0;
`endif
              state_q     <= S_HELD;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end
          S_HELD: begin
            if (rs_q == 4'hF && rel_q == DB_LAST) begin
              rel_q      <= '0;
              key_held_q <= 1'b0;
              ci_q       <= ci_d;
              col_q      <= col_of(ci_d);
              state_q    <= S_SCAN;
`ifdef KEYPAD_REPEAT_EN
              rep_q      <= '0;
`endif
            end else begin
              rel_q <= (rs_q == 4'hF) ? rel_q + 1'b1 : '0;
`ifdef KEYPAD_REPEAT_EN
              if (rel_q != '0) begin
                rep_q <= '0;
              end else if (rep_q == REP_LAST) begin
                rep_q       <= '0;
                key_valid_q <= 1'b1;
              end else begin
                rep_q <= rep_q + 1'b1;
              end
`endif
            end
          end
          default: state_q <= S_SCAN;
        endcase
      end
    end
  end

  assign Col      = col_q;
  assign Key      = key_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;

  logic       Clock;
  logic       Reset;
  logic       En;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] Key;
  logic       KeyValid;
  logic       KeyHeld;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          tests;
  int          fails;

  keypad_scanner #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (20)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .En      (En),
    .Row     (Row),
    .Col     (Col),
    .Key     (Key),
    .KeyValid(KeyValid),
    .KeyHeld (KeyHeld)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Key index is 4*row + col; a closed key pulls its row low while its column is strobed.
  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !Col[c]) Row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] c, input int max_cycles, input string name);
    int found;
    found = 0;
    for (int i = 0; i < max_cycles && found == 0; i++) begin
      @(negedge Clock);
      if (Col == c) found = 1;
    end
    check(name, found, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  always @(negedge Clock) begin
    if (!Reset && KeyValid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got Key=%0h expected no KeyValid", Key);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (Key !== e) begin
          fails++;
          $display("FAIL key_code: got %0h expected %0h", Key, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    keys  = 16'h0;
    En    = 1'b1;
    Reset = 1'b1;

    idle(3);
    check("rst_col", Col, 4'hF);
    check("rst_key", Key, 4'h0);
    check("rst_valid", KeyValid, 1'b0);
    check("rst_held", KeyHeld, 1'b0);
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] ec;
      @(negedge Clock);
      ec = ~(4'b0001 << ((i / 4) % 4));
      check("idle_sweep_col", Col, ec);
    end

    wait_col(4'b1011, 40, "clean_reach_col2");
    keys[10] = 1'b1;
    exp_q.push_back(4'hA);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clock);
      if (KeyValid && lat == 0) lat = i;
    end
    check("clean_latency", lat, 12);
    check("clean_held", KeyHeld, 1'b1);
    check("clean_key_stable", Key, 4'hA);
    keys = 16'h0;
    idle(9);
    check("clean_held_8_high", KeyHeld, 1'b1);
    idle(1);
    check("clean_released", KeyHeld, 1'b0);

    wait_col(4'b1110, 40, "bounce_reach_col0");
    for (int i = 0; i < 40; i++) begin
      keys[4] = ((i / 3) % 2) == 0;
      @(negedge Clock);
    end
    keys = 16'h0;
    wait_col(4'b0111, 40, "bounce_scan_col3");
    wait_col(4'b1110, 40, "bounce_scan_col0");

    wait_col(4'b0111, 40, "multi_reach_col3");
    keys[15] = 1'b1;
    keys[7]  = 1'b1;
    exp_q.push_back(4'h7);
    idle(30);
    check("multi_key", Key, 4'h7);
    keys = 16'h0;
    idle(20);

    wait_col(4'b1101, 40, "rst_mid_reach_col1");
    keys[1] = 1'b1;
    idle(6);
    Reset = 1'b1;
    #1;
    check("rst_mid_col", Col, 4'hF);
    check("rst_mid_key", Key, 4'h0);
    check("rst_mid_valid", KeyValid, 1'b0);
    check("rst_mid_held", KeyHeld, 1'b0);
    keys = 16'h0;
    idle(3);
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_mid_resume_col", Col, 4'b1110);
    idle(20);

    wait_col(4'b1101, 40, "rep_reach_col1");
    keys[5] = 1'b1;
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h5);
`else
    exp_q.push_back(4'h5);
`endif
    idle(82);
    keys = 16'h0;
    idle(30);

    En = 1'b0;
    @(negedge Clock);
    check("en_off_col", Col, 4'hF);
    check("en_off_key_holds", Key, 4'h5);
    check("en_off_held", KeyHeld, 1'b0);
    En = 1'b1;
    @(negedge Clock);
    check("en_on_col", Col, 4'b1110);

    idle(5);
    check("pulses_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
